// File: rtl/ain_debouncer.sv
// ain_debouncer: synchronizes the two raw push-button levels and drives a
// debounced 2-bit code onto ain for the downstream sequence detector.
// A new code is accepted only after it has been stable for DEBOUNCE_CYCLES
// clocks. Accepted changes pulse ain_changed, and abandoned candidates
// are counted in a saturating glitch counter.
module ain_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int GLITCH_W        = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          btn_raw,
  output logic [1:0]          ain,
  output logic                ain_changed,
  output logic                settling,
  output logic [GLITCH_W-1:0] glitch_count
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [1:0]          sync1, sync2;
  logic [1:0]          cand, cand_nxt;
  logic [1:0]          ain_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                ain_changed_nxt;
  logic [GLITCH_W-1:0] glitch_nxt;

  // Two-flop synchronizer for both button bits. Only sync2 is used past this point.
  // NOTE: sequential state is written with non-blocking assignments so that
  // every flop samples the pre-edge value of its neighbours; with blocking
  // assignments sync2 would pick up btn_raw in the same edge and the
  // synchronizer would collapse to a single stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Debounce FSM register plus its datapath (candidate, timer, outputs).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= STABLE;
      cand         <= 2'b00;
      cnt          <= '0;
      ain          <= 2'b00;
      ain_changed  <= 1'b0;
      glitch_count <= '0;
    end else begin
      state        <= state_nxt;
      cand         <= cand_nxt;
      cnt          <= cnt_nxt;
      ain          <= ain_nxt;
      ain_changed  <= ain_changed_nxt;
      glitch_count <= glitch_nxt;
    end
  end

  // Next-state logic: time the candidate, accept it, or reject it as a glitch.
  always_comb begin
    // NOTE: every signal driven here gets a hold/default value first, so
    // that no path through the case leaves a variable unassigned and
    // synthesis never infers a latch.
    state_nxt       = state;
    cand_nxt        = cand;
    cnt_nxt         = cnt;
    ain_nxt         = ain;
    ain_changed_nxt = 1'b0;
    glitch_nxt      = glitch_count;

    unique case (state)
      STABLE: begin
        if (sync2 != ain) begin
          cand_nxt  = sync2;
          cnt_nxt   = '0;
          state_nxt = SETTLING;
        end
      end

      SETTLING: begin
        if (sync2 == cand) begin
          if (cnt == CNT_LAST) begin
            ain_nxt         = cand;
            ain_changed_nxt = 1'b1;
            cnt_nxt         = '0;
            state_nxt       = STABLE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end else begin
          // The candidate moved before it was accepted: count one glitch.
          if (glitch_count != '1) begin
            glitch_nxt = glitch_count + 1'b1;
          end
          if (sync2 == ain) begin
            state_nxt = STABLE;
          end else begin
            cand_nxt = sync2;
            cnt_nxt  = '0;
          end
        end
      end

      default: state_nxt = STABLE;
    endcase
  end

  // The state flop itself is the settling indicator.
  assign settling = (state == SETTLING);

endmodule

// File: tb/tb_ain_debouncer.sv
// Self-checking bench for ain_debouncer. It runs directed scenarios and then
// a randomized button stream. A run-length reference model checks every
// output on every clock.
module tb_ain_debouncer;

  localparam int D    = 4;
  localparam int GW   = 2;
  localparam int GMAX = (1 << GW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    btn_raw;
  logic [1:0]    ain;
  logic          ain_changed;
  logic          settling;
  logic [GW-1:0] glitch_count;

  int total = 0;
  int bad   = 0;

  ain_debouncer #(
    .DEBOUNCE_CYCLES(D),
    .GLITCH_W(GW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .ain(ain),
    .ain_changed(ain_changed),
    .settling(settling),
    .glitch_count(glitch_count)
  );

  always #5 clk = ~clk;

  // Reference model. The synchronizer is a two-deep delay line. After that,
  // a code is accepted once D+1 consecutive samples of it have been seen and
  // it differs from ain. A glitch is a change of the sampled code while the
  // previous code was still pending (different from ain).
  logic [1:0] p1, p2, run_val, m_ain;
  int         run_len;
  int         m_glitch;
  logic       m_changed, m_settling;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    p1 = 2'b00; p2 = 2'b00;
    run_val = 2'b00; run_len = D + 1;
    m_ain = 2'b00; m_glitch = 0;
    m_changed = 1'b0; m_settling = 1'b0;
  endtask

  task automatic model_edge();
    logic [1:0] s;
    s  = p2;
    p2 = p1;
    p1 = btn_raw;
    m_changed = 1'b0;
    if (s == run_val) begin
      if (run_len < 1000000) run_len++;
    end else begin
      if (run_val != m_ain && m_glitch < GMAX) m_glitch++;
      run_val = s;
      run_len = 1;
    end
    if (run_len == D + 1 && s != m_ain) begin
      m_ain     = s;
      m_changed = 1'b1;
    end
    m_settling = (s != m_ain);
  endtask

  task automatic compare_all();
    check("ain", ain, m_ain);
    check("ain_changed", ain_changed, m_changed);
    check("settling", settling, m_settling);
    check("glitch_count", glitch_count, m_glitch);
  endtask

  // One clock: advance the model with the input present at the edge, then
  // sample the DUT 1 ns later.
  task automatic tick();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    compare_all();
  endtask

  // Enter reset with btn_raw at the given level. Outputs are checked right
  // away, before any clock edge, and reset is released on a falling edge.
  task automatic do_reset(input logic [1:0] btn);
    btn_raw = btn;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_ain", ain, 2'b00);
    check("rst_changed", ain_changed, 1'b0);
    check("rst_settling", settling, 1'b0);
    check("rst_glitch", glitch_count, 0);
    tick();
    tick();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Run n clocks. Report the clock index (1 = first sampling edge) of the
  // first ain_changed pulse, the number of pulses, and the settling cycles.
  task automatic run_watch(input int n, output int first_at, output int pulses,
                           output int settle_cnt);
    first_at = -1; pulses = 0; settle_cnt = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (ain_changed) begin
        pulses++;
        if (first_at < 0) first_at = i;
      end
      if (settling) settle_cnt++;
    end
  endtask

  initial begin
    int at, pulses, sc;
    bit saw_10;
    int sat_exp [5] = '{1, 2, 3, 3, 3};
    reset   = 1'b0;
    btn_raw = 2'b00;
    model_reset();

    // Reset with both buttons held. After release, 11 is accepted at edge k+6.
    do_reset(2'b11);
    run_watch(20, at, pulses, sc);
    check("rst_lat", at, D + 3);
    check("rst_pulses", pulses, 1);
    check("rst_ain11", ain, 2'b11);

    // Clean press 00 -> 01 and then release back to 00.
    do_reset(2'b00);
    run_watch(4, at, pulses, sc);
    btn_raw = 2'b01;
    run_watch(20, at, pulses, sc);
    check("press_lat", at, D + 3);
    check("press_pulses", pulses, 1);
    check("press_settle", sc, D);
    check("press_ain", ain, 2'b01);
    btn_raw = 2'b00;
    run_watch(20, at, pulses, sc);
    check("release_lat", at, D + 3);
    check("release_pulses", pulses, 1);
    check("release_ain", ain, 2'b00);

    // Short glitch: 10 for two clocks.
    do_reset(2'b00);
    run_watch(4, at, pulses, sc);
    btn_raw = 2'b10;
    tick(); tick();
    btn_raw = 2'b00;
    run_watch(8, at, pulses, sc);
    check("glitch_pulses", pulses, 0);
    check("glitch_cnt", glitch_count, 1);
    check("glitch_ain", ain, 2'b00);
    check("glitch_stable", settling, 1'b0);

    // Bounce: 11 for 2, 10 for 1, then 11 held. 10 must never appear on ain.
    do_reset(2'b00);
    run_watch(4, at, pulses, sc);
    saw_10 = 1'b0;
    btn_raw = 2'b11;
    tick(); if (ain == 2'b10) saw_10 = 1'b1;
    tick(); if (ain == 2'b10) saw_10 = 1'b1;
    btn_raw = 2'b10;
    tick(); if (ain == 2'b10) saw_10 = 1'b1;
    btn_raw = 2'b11;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ain == 2'b10) saw_10 = 1'b1;
      if (ain_changed) pulses++;
    end
    check("bounce_pulses", pulses, 1);
    check("bounce_ain", ain, 2'b11);
    check("bounce_glitch", glitch_count, 2);
    check("bounce_no10", saw_10, 1'b0);

    // Reset three clocks into SETTLING. Everything clears at once.
    do_reset(2'b00);
    run_watch(4, at, pulses, sc);
    btn_raw = 2'b11;
    run_watch(5, at, pulses, sc);
    check("mid_settling", settling, 1'b1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("mid_rst_ain", ain, 2'b00);
    check("mid_rst_settling", settling, 1'b0);
    check("mid_rst_changed", ain_changed, 1'b0);
    check("mid_rst_glitch", glitch_count, 0);
    tick(); tick();
    @(negedge clk);
    reset = 1'b0;
    run_watch(20, at, pulses, sc);
    check("mid_relat", at, D + 3);
    check("mid_ain11", ain, 2'b11);

    // Saturation with a 2-bit counter, then a clean press is still accepted.
    do_reset(2'b00);
    run_watch(4, at, pulses, sc);
    for (int g = 0; g < 5; g++) begin
      btn_raw = 2'b10;
      tick(); tick();
      btn_raw = 2'b00;
      run_watch(6, at, pulses, sc);
      check("sat_cnt", glitch_count, sat_exp[g]);
    end
    btn_raw = 2'b01;
    run_watch(20, at, pulses, sc);
    check("sat_press_lat", at, D + 3);
    check("sat_press_ain", ain, 2'b01);
    check("sat_hold", glitch_count, GMAX);

    // Randomized button stream with random hold times.
    do_reset(2'b00);
    for (int n = 0; n < 3000; n++) begin
      btn_raw = 2'($urandom_range(0, 3));
      for (int h = $urandom_range(1, 8); h > 0; h--) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ain_debouncer.md
Name: ain_debouncer

Overview:
Upstream conditioning stage for the two-button command FSM. Takes the two raw, asynchronous, bouncing push-button levels and synchronizes them to clk. It accepts a new 2-bit code only after the code has been stable for DEBOUNCE_CYCLES clocks, then drives the clean code onto ain for the downstream sequence detector. It also reports accepted changes and rejected glitches.

Parameters:
DEBOUNCE_CYCLES, 16, clocks a synchronized code must stay stable before acceptance; legal range >=1 (use 1_000_000 on board, 4 in simulation)
GLITCH_W, 8, width of the saturating rejected-glitch counter
(derived localparam CNT_W = $clog2(DEBOUNCE_CYCLES+1))

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
btn_raw  input  2  raw button levels, asynchronous to clk, may bounce
ain  output  2  debounced code; feeds the sequence detector's ain
ain_changed  output  1  one-cycle pulse in the same cycle ain takes a new value
settling  output  1  high while a candidate code is being timed
glitch_count  output  GLITCH_W  number of rejected candidates, saturating

Behaviour:
- Clock and reset: clk; reset is asynchronous, active-high. Reset is the only asynchronous path in the block.
- Reset values:
  - sync1 = sync2 = 2'b00, cand = 2'b00, cnt = 0
  - state = STABLE, ain = 2'b00, ain_changed = 0, settling = 0, glitch_count = 0
- Synchronizer: two flops per bit (btn_raw -> sync1 -> sync2). Only sync2 is used downstream of the synchronizer. Both bits share the same two-stage path; there is no per-bit skew handling.
- FSM state STABLE (settling=0):
  - If sync2 != ain: cand <= sync2, cnt <= 0, go to SETTLING.
  - Otherwise hold.
- FSM state SETTLING (settling=1):
  - If sync2 == cand and cnt != DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - If sync2 == cand and cnt == DEBOUNCE_CYCLES-1: ain <= cand, ain_changed <= 1 for exactly one cycle, cnt <= 0, go to STABLE.
  - If sync2 != cand: this is a glitch. glitch_count <= glitch_count+1, saturating at all-ones.
    - If sync2 == ain: go to STABLE, no pulse.
    - Else: cand <= sync2, cnt <= 0, stay in SETTLING (restart timing).
- Latency: with btn_raw held at a new value first sampled by sync1 at edge k:
  - SETTLING is entered at edge k+2.
  - ain updates, and ain_changed goes high, at edge k+DEBOUNCE_CYCLES+2.
  - This timing is exact for every legal DEBOUNCE_CYCLES, including 1.
- Outputs ain, ain_changed and settling are registered, with no combinational path from btn_raw.
- Any code is accepted, including 2'b00. Multi-bit transitions are handled identically: 01 -> 11 is an ordinary change, and 10 -> 01 is a single candidate.
- Bounce through an intermediate code (e.g. 00 -> 10 -> 11 within fewer than DEBOUNCE_CYCLES clocks) counts one glitch and restarts timing on the final code. The intermediate code never appears on ain.
- ain_changed never fires on consecutive cycles, because a minimum of DEBOUNCE_CYCLES+1 cycles separates two accepts.
- Reset asserted mid-SETTLING aborts immediately:
  - ain returns to 00 and glitch_count clears.
  - After release, a button still held is re-accepted with the normal latency.
- glitch_count at all-ones stays at all-ones on further glitches; accepts continue normally.

Test Plan:
- Reset/idle, DEBOUNCE_CYCLES=4: assert reset with btn_raw=11, release -> ain=00, ain_changed=0, glitch_count=0 immediately. ain=11 with a single ain_changed pulse exactly 6 edges after the first sampling edge.
- Clean press, DEBOUNCE_CYCLES=4: btn_raw 00 -> 01 held 20 cycles -> settling high for 4 cycles, ain=01 at edge k+6, one ain_changed pulse. Release to 00 -> ain=00 at edge k'+6, one pulse.
- Short glitch: btn_raw=10 for 2 cycles, then back to 00 -> ain stays 00, no ain_changed, glitch_count=1, state returns to STABLE.
- Bounce sequence: 00 -> 11 for 2 cycles -> 10 for 1 cycle -> 11 held -> ain goes straight 00 -> 11 with exactly one pulse, never 10. glitch_count=2 (11->10 and 10->11 transitions).
- Reset mid-settle: btn_raw=11 held, assert reset 3 cycles into SETTLING -> all outputs reset at once. After release, ain=11 at the 6th edge after sampling resumes.
- Saturation, GLITCH_W=2: generate 5 glitches -> glitch_count reads 1, 2, 3, 3, 3. A subsequent clean press is still accepted normally.
